// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline interlock sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LU_HOLD = 2'd1,
    FLUSHED = 2'd2
  } ctrl_state_e;

  localparam logic [31:0] NOP = 32'b0;

  // A fresh load-use stall may only start outside the post-stall hold cycle.
  function automatic logic lu_stall_allowed(input ctrl_state_e s);
    return (s != LU_HOLD);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline interlock sequencer: load-use stalls, redirect flushes, memory freeze,
// plus saturating debug counters and a sticky protocol-error flag.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             is_lw_i,
  input  logic             pcsel_i,
  input  logic             mem_busy_i,
  output logic             pc_we_o,
  output logic             if_id_we_o,
  output logic             id_ex_we_o,
  output logic             ex_ma_we_o,
  output logic             ma_wb_we_o,
  output logic             ma_bubble_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             hazard_err_o
);

  ctrl_state_e state_q, state_d;
  logic        hazard_err_q, hazard_err_d;
  logic        stall_evt_s, flush_evt_s, illegal_lu_s;

  // Request decode in priority order: busy, redirect, load-use.
  always_comb begin
    flush_evt_s  = 1'b0;
    stall_evt_s  = 1'b0;
    illegal_lu_s = 1'b0;
    if (mem_busy_i) begin
      flush_evt_s = 1'b0;
    end else if (pcsel_i) begin
      flush_evt_s = 1'b1;
    end else if (is_lw_i) begin
      stall_evt_s  = lu_stall_allowed(state_q);
      illegal_lu_s = (state_q != RUN);
    end else begin
      stall_evt_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      hazard_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hazard_err_q <= hazard_err_d;
    end
  end

  // Next-state logic; a freeze holds whatever state we are in.
  always_comb begin
    state_d      = state_q;
    hazard_err_d = hazard_err_q | illegal_lu_s;
    case (state_q)
      RUN, LU_HOLD, FLUSHED: begin
        if (mem_busy_i) begin
          state_d = state_q;
        end else if (flush_evt_s) begin
          state_d = FLUSHED;
        end else if (stall_evt_s) begin
          state_d = LU_HOLD;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Output decode; while in reset the outputs show the idle RUN values.
  always_comb begin
    pc_we_o     = 1'b1;
    if_id_we_o  = 1'b1;
    id_ex_we_o  = 1'b1;
    ex_ma_we_o  = 1'b1;
    ma_wb_we_o  = 1'b1;
    ma_bubble_o = 1'b0;
    flush_o     = 1'b0;
    if (!rst_n) begin
      flush_o = 1'b0;
    end else if (mem_busy_i) begin
      pc_we_o    = 1'b0;
      if_id_we_o = 1'b0;
      id_ex_we_o = 1'b0;
      ex_ma_we_o = 1'b0;
      ma_wb_we_o = 1'b0;
    end else if (flush_evt_s) begin
      flush_o = 1'b1;
    end else if (stall_evt_s) begin
      pc_we_o     = 1'b0;
      if_id_we_o  = 1'b0;
      id_ex_we_o  = 1'b0;
      ma_bubble_o = 1'b1;
    end else begin
      flush_o = 1'b0;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (stall_evt_s),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (flush_evt_s),
    .cnt_o (flush_cnt_o)
  );

  assign hazard_err_o = hazard_err_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline interlock sequencer for the 5-stage core; it consumes the hazard requests the decode/control logic raises, `is_lw` (load-use) and `PCsel` (taken branch/jump in WB), plus a data-memory busy flag. It produces PC and pipeline-register write enables, bubble insertion, and squash controls. A small FSM enforces one-cycle load-use stalls and single-cycle redirect flushes. Saturating event counters and a sticky protocol-error flag are provided for debug.

## Interface
- CNT_W, 16, width of each saturating event counter
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- is_lw_i  in  1  load in MA whose rd matches rs1/rs2 of the instruction in EX
- pcsel_i  in  1  taken bne/j resolved in WB; the PC mux redirects this cycle
- mem_busy_i  in  1  data memory not ready; freeze the whole pipeline
- pc_we_o  out  1  PC register load enable
- if_id_we_o, id_ex_we_o, ex_ma_we_o, ma_wb_we_o  out  1 each  pipeline register enables
- ma_bubble_o  out  1  load 32'b0 into EX/MA instead of the EX result
- flush_o  out  1  load 32'b0 into IF/ID, ID/EX, EX/MA and MA/WB
- stall_cnt_o  out  CNT_W  load-use stall cycles, saturating
- flush_cnt_o  out  CNT_W  redirect flushes, saturating
- hazard_err_o  out  1  sticky protocol violation flag

## Operation
- States: RUN, LU_HOLD, FLUSHED. Reset state is RUN. Reset values: counters 0, hazard_err_o 0.
- Request priority within a cycle is mem_busy_i, then pcsel_i, then is_lw_i.
- Freeze (mem_busy_i=1, any state): all *_we_o=0, ma_bubble_o=0, flush_o=0. State and counters hold. Pending requests are re-evaluated when busy drops, because their inputs come from frozen registers.
- Redirect (pcsel_i=1, not busy):
  - flush_o=1 and all *_we_o=1, so WB retires, the PC takes the target, and younger stages are zeroed.
  - is_lw_i is ignored in this cycle.
  - flush_cnt_o increments. Next state is FLUSHED.
- Load-use (is_lw_i=1, pcsel_i=0, not busy, state RUN or FLUSHED):
  - pc_we_o, if_id_we_o and id_ex_we_o are 0.
  - ex_ma_we_o=1 with ma_bubble_o=1, and ma_wb_we_o=1.
  - stall_cnt_o increments. Next state is LU_HOLD.
- LU_HOLD:
  - The load has moved to WB and EX/MA holds a bubble, so the WB bypass serves the consumer. All enables are 1 and next state is RUN.
  - If is_lw_i=1 here (not busy, no pcsel), the condition is illegal. Set hazard_err_o, treat the cycle as a normal advance (no second stall), and go to RUN.
- FLUSHED: one-cycle marker after a redirect. Behaves as RUN for request handling. If no request, next state is RUN. If is_lw_i=1 here (illegal, since MA holds a bubble), set hazard_err_o and still perform the stall.
- No request, not busy: all enables 1, bubble and flush 0, next state RUN.
- Counters saturate at 2^CNT_W-1 and never wrap. hazard_err_o clears only on reset.

## Timing
- All *_we_o, ma_bubble_o and flush_o are combinational from the inputs and the current state. They are valid in the same cycle the request is raised, with zero latency.
- State, counters and hazard_err_o update on the rising clk edge. Counter values are visible one cycle after the event.
- A load-use stall costs exactly 1 cycle. A redirect costs 4 squashed slots and occupies 1 controller cycle.
- pcsel_i together with mem_busy_i: the freeze wins, and the flush happens in the first non-busy cycle.
- pcsel_i in LU_HOLD: the redirect wins and next state is FLUSHED.
- Asynchronous reset mid-stall or mid-flush forces RUN immediately, with counters and flag at 0. While rst_n=0, enable outputs follow the RUN/no-request values.

## Structure
- Shared package `pipe_ctrl_pkg`: state enum {RUN, LU_HOLD, FLUSHED} and the NOP constant 32'b0.
- One sub-module, `sat_counter` (CNT_W param, inc, async active-low clear), instantiated twice.
- The rest is a single FSM and an output decode block.

## Test plan
- Reset with rst_n=0 for 3 cycles, then release with no requests → all enables 1, flush/bubble 0, both counters 0, state RUN.
- is_lw_i=1 for 1 cycle → pc/if_id/id_ex enables 0, ma_bubble_o=1 that cycle, all enables 1 the next cycle, stall_cnt_o=1.
- pcsel_i=1 and is_lw_i=1 in the same cycle → flush_o=1, ma_bubble_o=0, flush_cnt_o=1, stall_cnt_o=0.
- mem_busy_i=1 for 3 cycles with pcsel_i held → all enables 0 and flush_o=0 for 3 cycles, then flush_o=1 on the 4th cycle, flush_cnt_o=1.
- CNT_W=4, 20 load-use events separated by idle cycles → stall_cnt_o stops at 15.
- is_lw_i held for 2 consecutive cycles → first cycle stalls, second cycle is a normal advance, hazard_err_o=1 and stays set until reset.
